// File: rtl/router_csr_arb.sv
// Round-robin arbiter sharing the router CSR bus between NREQ requesters.
// Optional access timeout: define ROUTER_CSR_ARB_TIMEOUT_EN.
module router_csr_arb #(
  parameter int NREQ    = 2,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                     i_hclk,
  input  logic                     i_hreset,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_req_write,
  input  logic [NREQ*AWIDTH-1:0]   i_req_addr,
  input  logic [NREQ*DWIDTH-1:0]   i_req_wdata,
  output logic [NREQ-1:0]          o_ack,
  output logic [DWIDTH-1:0]        o_rdata,
  output logic                     o_err,
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
  output logic                     o_timeout,
`endif
  output logic [NREQ-1:0]          o_grant,
  output logic                     o_busy,
  output logic                     o_csr_write,
  output logic                     o_csr_read,
  output logic [AWIDTH-1:0]        o_csr_addr,
  output logic [DWIDTH-1:0]        o_csr_wdata,
  input  logic [DWIDTH-1:0]        i_csr_rdata,
  input  logic                     i_csr_error,
  input  logic                     i_csr_ready
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_last;
  logic            r_wr;
  logic [LW-1:0]   w_win;
  logic [NREQ-1:0] w_win_oh;

  // Scan downward so the nearest requester after r_last is assigned last.
  always_comb begin
    w_win = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(r_last) + k) % NREQ]) begin
        w_win = LW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  assign w_win_oh = NREQ'(1) << w_win;

`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] r_cnt;
  logic          w_to;
  assign w_to = (r_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state     <= S_IDLE;
      r_last      <= LW'(NREQ - 1);
      r_wr        <= 1'b0;
      o_ack       <= '0;
      o_rdata     <= '0;
      o_err       <= 1'b0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_csr_write <= 1'b0;
      o_csr_read  <= 1'b0;
      o_csr_addr  <= '0;
      o_csr_wdata <= '0;
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      o_timeout   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_state     <= S_ISSUE;
            r_last      <= w_win;
            r_wr        <= i_req_write[w_win];
            o_grant     <= w_win_oh;
            o_busy      <= 1'b1;
            o_csr_write <= i_req_write[w_win];
            o_csr_read  <= ~i_req_write[w_win];
            o_csr_addr  <= i_req_addr[w_win*AWIDTH +: AWIDTH];
            o_csr_wdata <= i_req_wdata[w_win*DWIDTH +: DWIDTH];
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        S_ISSUE: begin
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          if (i_csr_ready) begin
            r_state     <= S_DONE;
            o_ack       <= o_grant;
            o_rdata     <= r_wr ? '0 : i_csr_rdata;
            o_err       <= i_csr_error;
            o_csr_write <= 1'b0;
            o_csr_read  <= 1'b0;
          end
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
          else if (w_to) begin
            r_state     <= S_DONE;
            o_ack       <= o_grant;
            o_rdata     <= '0;
            o_err       <= 1'b1;
            o_timeout   <= 1'b1;
            o_csr_write <= 1'b0;
            o_csr_read  <= 1'b0;
          end
`endif
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          o_ack       <= '0;
          o_rdata     <= '0;
          o_err       <= 1'b0;
          o_grant     <= '0;
          o_busy      <= 1'b0;
          o_csr_addr  <= '0;
          o_csr_wdata <= '0;
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
          o_timeout   <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_csr_arb.sv
// Directed vector bench for router_csr_arb (NREQ=2).
// Timeout sequence runs when ROUTER_CSR_ARB_TIMEOUT_EN is defined.
module tb_router_csr_arb;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              clk;
  logic              hreset;
  logic [NREQ-1:0]   i_req;
  logic [NREQ-1:0]   i_req_write;
  logic [NREQ*AW-1:0] i_req_addr;
  logic [NREQ*DW-1:0] i_req_wdata;
  logic [NREQ-1:0]   o_ack;
  logic [DW-1:0]     o_rdata;
  logic              o_err;
  logic              o_timeout;
  logic [NREQ-1:0]   o_grant;
  logic              o_busy;
  logic              o_csr_write;
  logic              o_csr_read;
  logic [AW-1:0]     o_csr_addr;
  logic [DW-1:0]     o_csr_wdata;
  logic [DW-1:0]     i_csr_rdata;
  logic              i_csr_error;
  logic              i_csr_ready;

  int n_vec = 0;
  int n_err = 0;

  router_csr_arb #(
    .NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(8)
  ) dut (
    .i_hclk(clk),
    .i_hreset(hreset),
    .i_req(i_req),
    .i_req_write(i_req_write),
    .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_ack(o_ack),
    .o_rdata(o_rdata),
    .o_err(o_err),
`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
    .o_timeout(o_timeout),
`endif
    .o_grant(o_grant),
    .o_busy(o_busy),
    .o_csr_write(o_csr_write),
    .o_csr_read(o_csr_read),
    .o_csr_addr(o_csr_addr),
    .o_csr_wdata(o_csr_wdata),
    .i_csr_rdata(i_csr_rdata),
    .i_csr_error(i_csr_error),
    .i_csr_ready(i_csr_ready)
  );

`ifndef ROUTER_CSR_ARB_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          dly;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  e_grant;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    i_req       = v.req;
    i_req_write = v.wr;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    i_csr_rdata = v.rdata;
    i_csr_error = v.err;
    i_csr_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= v.dly; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d grant", id), 64'(o_grant), 64'(v.e_grant));
      chk($sformatf("v%0d wr", id), 64'(o_csr_write), 64'(v.e_wr));
      chk($sformatf("v%0d rd", id), 64'(o_csr_read), 64'(!v.e_wr));
      chk($sformatf("v%0d addr", id), 64'(o_csr_addr), 64'(v.e_addr));
      chk($sformatf("v%0d wdata", id), 64'(o_csr_wdata), 64'(v.e_wdata));
      chk($sformatf("v%0d busy", id), 64'(o_busy), 64'd1);
      chk($sformatf("v%0d early_ack", id), 64'(o_ack), 64'd0);
      i_csr_ready = (c == v.dly);
      @(posedge clk);
    end
    @(negedge clk);
    i_csr_ready = 1'b0;
    i_req       = '0;
    chk($sformatf("v%0d ack", id), 64'(o_ack), 64'(v.e_grant));
    chk($sformatf("v%0d rdata", id), 64'(o_rdata), 64'(v.e_rdata));
    chk($sformatf("v%0d err", id), 64'(o_err), 64'(v.e_err));
    chk($sformatf("v%0d strobes_off", id),
        64'({o_csr_write, o_csr_read}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d idle_ack", id), 64'(o_ack), 64'd0);
    chk($sformatf("v%0d idle_grant", id), 64'(o_grant), 64'd0);
    chk($sformatf("v%0d idle_busy", id), 64'(o_busy), 64'd0);
    chk($sformatf("v%0d idle_rdata", id), 64'(o_rdata), 64'd0);
  endtask

  logic [1:0] exp_g;

  initial begin
    vt[0] = '{2'b01, 2'b00, {32'h0, 32'h04}, 64'h0, 0, 32'hA5A5_0001,
              1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 32'hA5A5_0001, 1'b0};
    vt[1] = '{2'b10, 2'b10, {32'h10, 32'h0}, {32'hDEAD_BEEF, 32'h0}, 5,
              32'h1234_5678, 1'b0, 2'b10, 1'b1, 32'h10, 32'hDEAD_BEEF,
              32'h0, 1'b0};
    vt[2] = '{2'b01, 2'b00, {32'h0, 32'h3C}, 64'h0, 2, 32'hFFFF_0000,
              1'b1, 2'b01, 1'b0, 32'h3C, 32'h0, 32'hFFFF_0000, 1'b1};
    vt[3] = '{2'b01, 2'b00, {32'h0, 32'h08}, 64'h0, 0, 32'h0000_0055,
              1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 32'h0000_0055, 1'b0};
    vt[4] = '{2'b11, 2'b00, {32'h200, 32'h100}, {32'h2222, 32'h1111}, 1,
              32'h0BAD_F00D, 1'b0, 2'b10, 1'b0, 32'h200, 32'h2222,
              32'h0BAD_F00D, 1'b0};
    vt[5] = '{2'b11, 2'b11, {32'h48, 32'h44},
              {32'h2222_2222, 32'h1111_1111}, 0, 32'h77, 1'b0, 2'b01,
              1'b1, 32'h44, 32'h1111_1111, 32'h0, 1'b0};

    hreset      = 1'b1;
    i_req       = '0;
    i_req_write = '0;
    i_req_addr  = '0;
    i_req_wdata = '0;
    i_csr_rdata = '0;
    i_csr_error = 1'b0;
    i_csr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(o_ack), 64'd0);
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_strobes", 64'({o_csr_write, o_csr_read}), 64'd0);
    chk("rst_addr", 64'(o_csr_addr), 64'd0);
    chk("rst_rdata", 64'({o_rdata, o_err, o_timeout}), 64'd0);
    hreset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

    // Continuous contention, last grant was 0; ready held high throughout.
    i_req       = 2'b11;
    i_req_write = 2'b00;
    i_req_addr  = {32'hB0, 32'hA0};
    i_csr_rdata = 32'hC0DE_0000;
    i_csr_error = 1'b0;
    i_csr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d grant", k), 64'(o_grant), 64'(exp_g));
      chk($sformatf("rr%0d addr", k), 64'(o_csr_addr),
          (k % 2 == 0) ? 64'hB0 : 64'hA0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d ack", k), 64'(o_ack), 64'(exp_g));
      chk($sformatf("rr%0d rdata", k), 64'(o_rdata), 64'hC0DE_0000);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d idle", k), 64'({o_busy, o_ack}), 64'd0);
    end
    i_req       = '0;
    i_csr_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of an ISSUE cycle.
    i_req      = 2'b10;
    i_req_addr = {32'h80, 32'h0};
    @(posedge clk);
    @(negedge clk);
    chk("mid_rd_on", 64'(o_csr_read), 64'd1);
    chk("mid_grant", 64'(o_grant), 64'b10);
    #1 hreset = 1'b1;
    #1;
    chk("mid_strobes", 64'({o_csr_write, o_csr_read}), 64'd0);
    chk("mid_grant_clr", 64'(o_grant), 64'd0);
    chk("mid_busy", 64'(o_busy), 64'd0);
    chk("mid_ack", 64'(o_ack), 64'd0);
    @(negedge clk);
    chk("mid_ack2", 64'(o_ack), 64'd0);
    hreset      = 1'b0;
    i_req       = 2'b11;
    i_req_addr  = {32'h84, 32'h88};
    i_csr_rdata = 32'h5A5A_5A5A;
    i_csr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_grant", 64'(o_grant), 64'b01);
    chk("post_rst_addr", 64'(o_csr_addr), 64'h88);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ack", 64'(o_ack), 64'b01);
    chk("post_rst_rdata", 64'(o_rdata), 64'h5A5A_5A5A);
    i_req       = '0;
    i_csr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", 64'(o_busy), 64'd0);

`ifdef ROUTER_CSR_ARB_TIMEOUT_EN
    // Last grant 0, only requester 1 asks; ready never comes.
    i_req       = 2'b10;
    i_req_write = 2'b00;
    i_req_addr  = {32'h0C, 32'h0};
    i_csr_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("to%0d rd", c), 64'(o_csr_read), 64'd1);
      chk($sformatf("to%0d ack", c), 64'({o_ack, o_timeout}), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    i_req = '0;
    chk("to_ack", 64'(o_ack), 64'b10);
    chk("to_err", 64'(o_err), 64'd1);
    chk("to_flag", 64'(o_timeout), 64'd1);
    chk("to_rdata", 64'(o_rdata), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("to_clear", 64'({o_timeout, o_ack, o_err}), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
